// File: rtl/nat_pkg.sv
// nat_pkg: shared definitions for the NAT ingress parser and the lookup core.
//   - beat-index constants of the fixed Ethernet/IPv4/L4 header layout
//   - nat_tuple_t: the 5-tuple record handed to the lookup core
//   - default ethertype / protocol values
//   - bcnt_next: beat counter step (saturating, cleared at end of frame)
package nat_pkg;

   localparam logic [2:0] BEAT_FIRST   = 3'd0;
   localparam logic [2:0] BEAT_ETYPE   = 3'd1;
   localparam logic [2:0] BEAT_PROTO   = 3'd2;
   localparam logic [2:0] BEAT_IP      = 3'd3;
   localparam logic [2:0] BEAT_PORT    = 3'd4;
   localparam logic [2:0] BEAT_PAYLOAD = 3'd5;

   // Ethertype as it appears on the little-endian beat (byte 12 = 0x08).
   localparam logic [15:0] NAT_ETYPE_IPV4 = 16'h0008;
   localparam logic [7:0]  NAT_PROTO_TCP  = 8'h06;
   localparam logic [7:0]  NAT_PROTO_UDP  = 8'h11;

   typedef struct packed {
      logic [31:0] src_ip;
      logic [31:0] dst_ip;
      logic [15:0] src_port;
      logic [15:0] dst_port;
      logic [7:0]  proto;
   } nat_tuple_t;

   // Next beat index for an accepted beat: 0 after tlast, else +1 saturating at payload.
   function automatic logic [2:0] bcnt_next(input logic [2:0] bcnt, input logic last);
      logic [2:0] nxt;
      if (last) begin
         nxt = BEAT_FIRST;
      end else if (bcnt >= BEAT_PAYLOAD) begin
         nxt = BEAT_PAYLOAD;
      end else begin
         nxt = bcnt + 3'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: single-stage AXI-Stream register slice (64-bit data + keep + last).
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   s_data/s_keep/s_last/s_valid   upstream beat (s_valid must already include s_ready)
//   s_ready                        slice can take a beat this cycle
//   m_data/m_keep/m_last/m_valid   registered downstream beat
//   m_ready                        downstream ready
// A held beat keeps valid and data stable until the downstream handshake.
module axis_reg_slice (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] s_data,
   input  logic [7:0]  s_keep,
   input  logic        s_last,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [63:0] m_data,
   output logic [7:0]  m_keep,
   output logic        m_last,
   output logic        m_valid,
   input  logic        m_ready
);

   assign s_ready = !m_valid || m_ready;

   // Output register: load on accept, drop valid only after a handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_data  <= 64'h0;
         m_keep  <= 8'h00;
         m_last  <= 1'b0;
         m_valid <= 1'b0;
      end else if (s_valid && s_ready) begin
         m_data  <= s_data;
         m_keep  <= s_keep;
         m_last  <= s_last;
         m_valid <= 1'b1;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end else begin
         m_valid <= m_valid;
      end
   end

endmodule

// File: rtl/nat_tuple_extract.sv
// nat_tuple_extract: ingress header parser in front of the NAT lookup core.
// Forwards every AXI-Stream beat through one register stage and emits exactly
// one IPv4 5-tuple record per frame on the t_* valid/ready port.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   s_axis_*              ingress frame stream (64-bit, keep, last)
//   m_axis_*              egress frame stream, 1-cycle delayed copy of ingress
//   t_src_ip..t_proto     tuple record fields, t_hit = translatable TCP(/UDP) IPv4 frame
//   t_valid, t_ready      tuple record handshake (one-entry slot)
// Build option: define NAT_UDP_EN to also accept PROTO_UDP as translatable.
module nat_tuple_extract
   import nat_pkg::*;
#(
   parameter logic [15:0] ETH_TYPE_IPV4 = NAT_ETYPE_IPV4,
   parameter logic [7:0]  PROTO_TCP     = NAT_PROTO_TCP,
   parameter logic [7:0]  PROTO_UDP     = NAT_PROTO_UDP
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] s_axis_tdata,
   input  logic [7:0]  s_axis_tkeep,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [63:0] m_axis_tdata,
   output logic [7:0]  m_axis_tkeep,
   output logic        m_axis_tlast,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [31:0] t_src_ip,
   output logic [31:0] t_dst_ip,
   output logic [15:0] t_src_port,
   output logic [15:0] t_dst_port,
   output logic [7:0]  t_proto,
   output logic        t_hit,
   output logic        t_valid,
   input  logic        t_ready
);

`ifdef NAT_UDP_EN
   localparam logic UDP_EN = 1'b1;
`else
   localparam logic UDP_EN = 1'b0;
`endif

   logic        slice_ready;
   logic        accept;
   logic        gen_next;
   logic [2:0]  bcnt;

   // Header fields captured so far in the current frame.
   logic [15:0] etype_cap;
   logic [7:0]  proto_cap;
   logic [31:0] src_ip_cap;
   logic [15:0] dst_lo_cap;   // dst_ip[15:0], carried on beat 3

   // Capture values including the beat currently on the input.
   logic [15:0] etype_nxt;
   logic [7:0]  proto_nxt;
   logic [31:0] src_ip_nxt;
   logic [15:0] dst_lo_nxt;
   logic        proto_ok;
   logic        hit_nxt;
   nat_tuple_t  rec_nxt;

   nat_tuple_t  tup;

   // Stall ingress when this beat would create a record but the slot is full and not draining.
   assign s_axis_tready = rst_n && slice_ready && !(gen_next && t_valid && !t_ready);
   assign accept        = s_axis_tvalid && s_axis_tready;

   axis_reg_slice u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_data  (s_axis_tdata),
      .s_keep  (s_axis_tkeep),
      .s_last  (s_axis_tlast),
      .s_valid (accept),
      .s_ready (slice_ready),
      .m_data  (m_axis_tdata),
      .m_keep  (m_axis_tkeep),
      .m_last  (m_axis_tlast),
      .m_valid (m_axis_tvalid),
      .m_ready (m_axis_tready)
   );

   // Field extraction and record build for the beat on the input.
   always_comb begin
      etype_nxt  = (bcnt == BEAT_ETYPE) ? s_axis_tdata[47:32] : etype_cap;
      proto_nxt  = (bcnt == BEAT_PROTO) ? s_axis_tdata[63:56] : proto_cap;
      src_ip_nxt = (bcnt == BEAT_IP)    ? s_axis_tdata[47:16] : src_ip_cap;
      dst_lo_nxt = (bcnt == BEAT_IP)    ? s_axis_tdata[63:48] : dst_lo_cap;

      // Beat 4 always generates; a runt ends before it, so its beat-4 fields stay zero.
      rec_nxt.src_ip = src_ip_nxt;
      rec_nxt.proto  = proto_nxt;
      if (bcnt == BEAT_PORT) begin
         rec_nxt.dst_ip   = {s_axis_tdata[15:0], dst_lo_nxt};
         rec_nxt.src_port = s_axis_tdata[31:16];
         rec_nxt.dst_port = s_axis_tdata[47:32];
      end else begin
         rec_nxt.dst_ip   = {16'h0000, dst_lo_nxt};
         rec_nxt.src_port = 16'h0000;
         rec_nxt.dst_port = 16'h0000;
      end

      proto_ok = (proto_nxt == PROTO_TCP) || (UDP_EN && (proto_nxt == PROTO_UDP));
      hit_nxt  = (etype_nxt == ETH_TYPE_IPV4) && proto_ok && (bcnt == BEAT_PORT);

      gen_next = s_axis_tvalid &&
                 ((bcnt == BEAT_PORT) || (s_axis_tlast && (bcnt < BEAT_PORT)));
   end

   // Beat counter and header capture; everything is cleared at end of frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bcnt       <= BEAT_FIRST;
         etype_cap  <= 16'h0000;
         proto_cap  <= 8'h00;
         src_ip_cap <= 32'h0;
         dst_lo_cap <= 16'h0000;
      end else if (accept) begin
         bcnt <= bcnt_next(bcnt, s_axis_tlast);
         if (s_axis_tlast) begin
            etype_cap  <= 16'h0000;
            proto_cap  <= 8'h00;
            src_ip_cap <= 32'h0;
            dst_lo_cap <= 16'h0000;
         end else begin
            etype_cap  <= etype_nxt;
            proto_cap  <= proto_nxt;
            src_ip_cap <= src_ip_nxt;
            dst_lo_cap <= dst_lo_nxt;
         end
      end else begin
         bcnt <= bcnt;
      end
   end

   // One-entry tuple slot; a new record may replace one draining in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tup     <= '0;
         t_hit   <= 1'b0;
         t_valid <= 1'b0;
      end else if (accept && gen_next) begin
         tup     <= rec_nxt;
         t_hit   <= hit_nxt;
         t_valid <= 1'b1;
      end else if (t_valid && t_ready) begin
         t_valid <= 1'b0;
      end else begin
         t_valid <= t_valid;
      end
   end

   assign t_src_ip   = tup.src_ip;
   assign t_dst_ip   = tup.dst_ip;
   assign t_src_port = tup.src_port;
   assign t_dst_port = tup.dst_port;
   assign t_proto    = tup.proto;

endmodule

// File: tb/tb_nat_tuple_extract.sv
// tb_nat_tuple_extract: directed self-checking bench for nat_tuple_extract.
// Inputs change 1 ns after posedge; outputs are sampled on negedge.
`timescale 1ns/1ps
module tb_nat_tuple_extract;

`ifdef NAT_UDP_EN
   localparam logic UDP_HIT = 1'b1;
`else
   localparam logic UDP_HIT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] s_axis_tdata;
   logic [7:0]  s_axis_tkeep;
   logic        s_axis_tlast;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [63:0] m_axis_tdata;
   logic [7:0]  m_axis_tkeep;
   logic        m_axis_tlast;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic [31:0] t_src_ip, t_dst_ip;
   logic [15:0] t_src_port, t_dst_port;
   logic [7:0]  t_proto;
   logic        t_hit, t_valid, t_ready;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      int          cyc;
   } beat_t;

   typedef struct {
      logic [31:0] sip, dip;
      logic [15:0] sp, dp;
      logic [7:0]  proto;
      logic        hit;
      logic        chkp;
   } rec_t;

   beat_t eq[$];
   rec_t  rq[$];
   int    n_chk = 0;
   int    n_fail = 0;
   int    cyc = 0;
   int    rec_cnt = 0;
   int    wait_cnt[8];
   logic  rand_mode = 1'b0;
   logic  lat_chk = 1'b1;

   nat_tuple_extract dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .t_src_ip(t_src_ip), .t_dst_ip(t_dst_ip), .t_src_port(t_src_port),
      .t_dst_port(t_dst_port), .t_proto(t_proto), .t_hit(t_hit),
      .t_valid(t_valid), .t_ready(t_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Egress sink readiness: always ready, or 50% random.
   always @(posedge clk) begin
      #1;
      if (rand_mode) m_axis_tready = 1'($urandom_range(0, 1));
      else           m_axis_tready = 1'b1;
   end

   // Egress monitor: order/content, latency, and hold-until-handshake.
   logic        e_pv = 1'b0, e_pr = 1'b0;
   logic [63:0] e_pd = 64'h0;
   always @(negedge clk) begin
      beat_t e;
      if (m_axis_tvalid && m_axis_tready) begin
         if (eq.size() == 0) begin
            check("eg_unexpected", 64'd1, 64'd0);
         end else begin
            e = eq.pop_front();
            check("eg_data", m_axis_tdata, e.data);
            check("eg_keep", 64'(m_axis_tkeep), 64'(e.keep));
            check("eg_last", 64'(m_axis_tlast), 64'(e.last));
            if (lat_chk) check("eg_latency", 64'(cyc), 64'(e.cyc));
         end
      end
      if (e_pv && !e_pr) begin
         check("eg_hold_valid", 64'(m_axis_tvalid), 64'd1);
         check("eg_hold_data", m_axis_tdata, e_pd);
      end
      e_pv <= m_axis_tvalid && rst_n;
      e_pr <= m_axis_tready;
      e_pd <= m_axis_tdata;
   end

   // Tuple monitor: record order/content and stability while stalled.
   logic        t_pv = 1'b0, t_pr = 1'b0;
   logic [31:0] t_psip = 32'h0;
   logic [15:0] t_psp = 16'h0;
   always @(negedge clk) begin
      rec_t r;
      if (t_valid && t_ready) begin
         rec_cnt <= rec_cnt + 1;
         if (rq.size() == 0) begin
            check("rec_unexpected", 64'd1, 64'd0);
         end else begin
            r = rq.pop_front();
            check("t_src_ip", 64'(t_src_ip), 64'(r.sip));
            check("t_dst_ip", 64'(t_dst_ip), 64'(r.dip));
            check("t_src_port", 64'(t_src_port), 64'(r.sp));
            check("t_dst_port", 64'(t_dst_port), 64'(r.dp));
            if (r.chkp) check("t_proto", 64'(t_proto), 64'(r.proto));
            check("t_hit", 64'(t_hit), 64'(r.hit));
         end
      end
      if (t_pv && !t_pr) begin
         check("t_hold_valid", 64'(t_valid), 64'd1);
         check("t_hold_sip", 64'(t_src_ip), 64'(t_psip));
         check("t_hold_sport", 64'(t_src_port), 64'(t_psp));
      end
      t_pv   <= t_valid && rst_n;
      t_pr   <= t_ready;
      t_psip <= t_src_ip;
      t_psp  <= t_src_port;
   end

   task automatic finish_run();
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   endtask

   // Drive one beat; entered and left 1 ns after a posedge.
   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, output int w);
      bit done = 1'b0;
      beat_t b;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      w = 0;
      while (!done) begin
         @(negedge clk);
         if (s_axis_tready) begin
            b.data = d; b.keep = k; b.last = l; b.cyc = cyc + 1;
            eq.push_back(b);
            done = 1'b1;
         end else begin
            w++;
            if (w > 2000) begin
               check("ingress_timeout", 64'd1, 64'd0);
               finish_run();
            end
         end
         @(posedge clk);
         #1;
      end
      s_axis_tvalid = 1'b0;
   endtask

   // Build a frame with the tuple fields at their header positions; send beats 0..stop-1.
   task automatic send_frame(input logic [15:0] et, input logic [7:0] pr, input logic [31:0] sip,
                             input logic [31:0] dip, input logic [15:0] sp, input logic [15:0] dp,
                             input int len, input logic [15:0] tag, input int stop);
      logic [63:0] b;
      int w;
      for (int i = 0; i < stop; i++) begin
         case (i)
            0: b = {tag, 48'h0000_1111_2222};
            1: b = {16'h5566, et, 32'h7788_99AA};
            2: b = {pr, tag, 40'h11_2222_3333};
            3: b = {dip[15:0], sip, 16'h4500};
            4: b = {16'hBEEF, dp, sp, dip[31:16]};
            default: b = {tag, 8'(i), 40'hA5_A5A5_A5A5};
         endcase
         send_beat(b, (i == len - 1) ? 8'h0F : 8'hFF, i == len - 1, w);
         wait_cnt[i] = w;
      end
   endtask

   task automatic push_rec(input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] sp,
                           input logic [15:0] dp, input logic [7:0] pr, input logic hit,
                           input logic chkp);
      rec_t r;
      r.sip = sip; r.dip = dip; r.sp = sp; r.dp = dp; r.proto = pr; r.hit = hit; r.chkp = chkp;
      rq.push_back(r);
   endtask

   // Wait (bounded) for all expected beats/records, then check the record count.
   task automatic drain(input string tag, input int base, input int n);
      int t = 0;
      while ((eq.size() != 0 || rq.size() != 0) && t < 400) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      check({tag, "_drain"}, 64'(eq.size() + rq.size()), 64'd0);
      check({tag, "_rec_cnt"}, 64'(rec_cnt - base), 64'(n));
   endtask

   int base;
   int lens[10] = '{7, 3, 5, 8, 2, 6, 7, 1, 5, 7};

   initial begin
      rst_n = 1'b0;
      s_axis_tdata = 64'h0; s_axis_tkeep = 8'h00; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
      t_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
      check("rst_t_valid", 64'(t_valid), 64'd0);
      check("rst_s_ready", 64'(s_axis_tready), 64'd0);
      check("rst_m_data", m_axis_tdata, 64'h0);
      check("rst_t_fields", {t_src_ip, t_dst_port, t_proto, 7'd0, t_hit}, 64'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Basic TCP frame, UDP frame, non-IPv4 frame.
      base = rec_cnt;
      push_rec(32'h0A000001, 32'hC0A80002, 16'h1234, 16'h0050, 8'h06, 1'b1, 1'b1);
      send_frame(16'h0008, 8'h06, 32'h0A000001, 32'hC0A80002, 16'h1234, 16'h0050, 7, 16'h0001, 7);
      push_rec(32'h0A000001, 32'hC0A80002, 16'h1234, 16'h0050, 8'h11, UDP_HIT, 1'b1);
      send_frame(16'h0008, 8'h11, 32'h0A000001, 32'hC0A80002, 16'h1234, 16'h0050, 7, 16'h0002, 7);
      push_rec(32'h0A000001, 32'hC0A80002, 16'h1234, 16'h0050, 8'h06, 1'b0, 1'b1);
      send_frame(16'h0608, 8'h06, 32'h0A000001, 32'hC0A80002, 16'h1234, 16'h0050, 7, 16'h0003, 7);
      drain("basic", base, 3);

      // Runts (3 beats, 1 beat), each followed by a normal frame; tlast on beat 4.
      base = rec_cnt;
      push_rec(32'h0, 32'h0, 16'h0, 16'h0, 8'h06, 1'b0, 1'b0);
      send_frame(16'h0008, 8'h06, 32'h0A000001, 32'hC0A80002, 16'h1234, 16'h0050, 3, 16'h0004, 3);
      push_rec(32'h0A000005, 32'hC0A80006, 16'h4321, 16'h0016, 8'h06, 1'b1, 1'b1);
      send_frame(16'h0008, 8'h06, 32'h0A000005, 32'hC0A80006, 16'h4321, 16'h0016, 7, 16'h0005, 7);
      push_rec(32'h0, 32'h0, 16'h0, 16'h0, 8'h00, 1'b0, 1'b0);
      send_frame(16'h0008, 8'h06, 32'h0A000001, 32'hC0A80002, 16'h1234, 16'h0050, 1, 16'h0006, 1);
      push_rec(32'h0A000007, 32'hC0A80008, 16'h1111, 16'h2222, 8'h06, 1'b1, 1'b1);
      send_frame(16'h0008, 8'h06, 32'h0A000007, 32'hC0A80008, 16'h1111, 16'h2222, 5, 16'h0007, 5);
      drain("runt", base, 4);

      // Back-to-back frames with a 20-cycle tuple stall starting at frame 3.
      base = rec_cnt;
      for (int f = 0; f < 1024; f++) begin
         if (f == 3) begin
            t_ready = 1'b0;
            fork
               begin
                  repeat (20) @(posedge clk);
                  #1 t_ready = 1'b1;
               end
            join_none
         end
         push_rec(32'h0A000000 + 32'(f), 32'hC0A80000 + 32'(f), 16'(f), 16'h0050, 8'h06, 1'b1, 1'b1);
         send_frame(16'h0008, 8'h06, 32'h0A000000 + 32'(f), 32'hC0A80000 + 32'(f), 16'(f), 16'h0050,
                    7, 16'(f), 7);
         if (f == 4) begin
            check("stall_f4_b4", 64'(wait_cnt[4] > 0), 64'd1);
            check("nostall_f4_b3", 64'(wait_cnt[3]), 64'd0);
         end
      end
      drain("b2b", base, 1024);

      // Random egress backpressure.
      rand_mode = 1'b1;
      lat_chk   = 1'b0;
      base = rec_cnt;
      for (int k = 0; k < 20; k++) begin
         if (lens[k % 10] >= 5)
            push_rec(32'h0B000000 + 32'(k), 32'hAC100000 + 32'(k), 16'h1000 + 16'(k), 16'h01BB,
                     8'h06, 1'b1, 1'b1);
         else
            push_rec(32'h0, 32'h0, 16'h0, 16'h0, 8'h06, 1'b0, 1'b0);
         send_frame(16'h0008, 8'h06, 32'h0B000000 + 32'(k), 32'hAC100000 + 32'(k),
                    16'h1000 + 16'(k), 16'h01BB, lens[k % 10], 16'h0100 + 16'(k), lens[k % 10]);
      end
      drain("rand", base, 20);
      rand_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1 lat_chk = 1'b1;

      // Reset at frame 2 beat 3: frame 2 yields no record, frame 3 parses normally.
      base = rec_cnt;
      push_rec(32'h0A000010, 32'hC0A80010, 16'h0010, 16'h0050, 8'h06, 1'b1, 1'b1);
      send_frame(16'h0008, 8'h06, 32'h0A000010, 32'hC0A80010, 16'h0010, 16'h0050, 7, 16'h0200, 7);
      push_rec(32'h0A000011, 32'hC0A80011, 16'h0011, 16'h0050, 8'h06, 1'b1, 1'b1);
      send_frame(16'h0008, 8'h06, 32'h0A000011, 32'hC0A80011, 16'h0011, 16'h0050, 7, 16'h0201, 7);
      send_frame(16'h0008, 8'h06, 32'h0A000012, 32'hC0A80012, 16'h0012, 16'h0050, 7, 16'h0202, 3);
      rst_n = 1'b0;
      #1 check("midrst_s_ready", 64'(s_axis_tready), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("midrst_m_valid", 64'(m_axis_tvalid), 64'd0);
      check("midrst_t_valid", 64'(t_valid), 64'd0);
      check("midrst_m_data", m_axis_tdata, 64'h0);
      check("midrst_t_sip", 64'(t_src_ip), 64'h0);
      @(posedge clk);
      #1;
      push_rec(32'h0A000013, 32'hC0A80013, 16'h0013, 16'h0050, 8'h06, 1'b1, 1'b1);
      send_frame(16'h0008, 8'h06, 32'h0A000013, 32'hC0A80013, 16'h0013, 16'h0050, 7, 16'h0203, 7);
      drain("rst", base, 3);

      finish_run();
   end

endmodule
